stabilizer_readout_collector: RTL and testbench
===============================================

# stabilizer_readout_collector

Receiving end of the final stabilizer-matrix readout stream from the emulator control unit. The control unit rotates out one row per cycle (literals + phase) under `row_valid`, then pulses `done_readout`. This block captures the frame into a row buffer, checks its length, and replays it to a downstream host port with a valid/ready handshake and a last-row marker.

## Interface
Parameters:
- `NUM_QUBIT`, 4: rows per frame and qubits per row (≥2).
- `PHASE_W`, 2: phase field width per row.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `row_valid` in 1: readout row strobe from the control unit; one row per asserted cycle; no backpressure.
- `row_literal` in 2*NUM_QUBIT: row literals, {x[NUM_QUBIT-1:0], z[NUM_QUBIT-1:0]}.
- `row_phase` in PHASE_W: row phase.
- `done_readout` in 1: single-cycle end-of-frame pulse.
- `m_ready` in 1: host accepts a word.
- `clr_err` in 1: clears the sticky error flags.
- `m_valid` out 1: host word valid.
- `m_data` out 2*NUM_QUBIT+PHASE_W: {phase, literals} of the current row.
- `m_last` out 1: the current word is the final row of the frame.
- `m_index` out clog2(NUM_QUBIT): row index of the current word.
- `busy` out 1: high in CAPTURE or DRAIN.
- `frame_done` out 1: one-cycle pulse when the last row is accepted.
- `short_err` out 1: sticky; the frame ended with fewer than NUM_QUBIT rows.
- `long_err` out 1: sticky; the frame had more than NUM_QUBIT rows.
- `overrun_err` out 1: sticky; `row_valid` arrived during DRAIN.

## Operation
- Storage: NUM_QUBIT-entry row buffer, write pointer `wr_cnt` (0..NUM_QUBIT) and read pointer `rd_ptr`.
- State IDLE:
  - `row_valid` writes entry 0, sets `wr_cnt`=1 and moves to CAPTURE.
  - `done_readout` alone sets `short_err` and stays in IDLE.
- State CAPTURE:
  - `row_valid` with `wr_cnt`<NUM_QUBIT writes entry `wr_cnt` and increments it.
  - `row_valid` with `wr_cnt`==NUM_QUBIT drops the row and sets `long_err`; stored rows are untouched.
  - `done_readout` with `wr_cnt`==NUM_QUBIT moves to DRAIN with `rd_ptr`=0.
  - `done_readout` with `wr_cnt`<NUM_QUBIT sets `short_err`, discards the frame (`wr_cnt`=0) and returns to IDLE.
  - Simultaneous `row_valid` and `done_readout`: the row is processed first (written, or dropped if full), then the length check uses the updated count.
- State DRAIN:
  - `m_valid`=1, `m_data`=buffer[`rd_ptr`], `m_index`=`rd_ptr`, `m_last`=(`rd_ptr`==NUM_QUBIT-1).
  - A handshake (`m_valid`&`m_ready`) increments `rd_ptr`.
  - Handshake on the last row: `frame_done` pulses the next cycle, state returns to IDLE and `wr_cnt` clears.
  - `row_valid` sets `overrun_err` and the row is dropped; `done_readout` is ignored.
- Error flags:
  - Sticky until a cycle with `clr_err`=1.
  - When `clr_err` coincides with a new error event, the set wins.
- Rows are emitted in arrival order; no reordering of the control unit's rotate-down order.

## Timing
- Reset values: state IDLE, `wr_cnt`=0, `rd_ptr`=0, buffer contents don't-care, and all outputs 0 (`m_valid`, `m_last`, `m_index`, `busy`, `frame_done`, all error flags; `m_data`=0).
- Reset mid-frame (CAPTURE or DRAIN) aborts immediately; no `frame_done` pulse.
- Capture: row data is sampled on the same edge as `row_valid`; consecutive back-to-back rows are required.
- Latency: `m_valid` rises one cycle after the edge that samples a good `done_readout`.
- With `m_ready` held high, a frame drains in NUM_QUBIT cycles, and `frame_done` follows the last handshake by one cycle.
- Host rule: `m_data`, `m_index` and `m_last` are stable while `m_valid`=1 and `m_ready`=0.
- The next frame's first `row_valid` is accepted in the cycle the state is IDLE, i.e. the cycle `frame_done` is high.

## Test plan
- **Nominal frame:** NUM_QUBIT=4; rows 0x0A1,0x0B2,0x0C3,0x0D4 on 4 consecutive cycles, `done_readout` the next cycle, `m_ready`=1 → `m_data` sequence 0x0A1..0x0D4 with `m_index` 0..3, `m_last` only on 0x0D4, `frame_done` one cycle later, no errors.
- **Backpressure:** same frame with `m_ready` toggling 1,0,0,1,… → each word is held stable while stalled, 4 handshakes in order, `busy` stays high until the last one.
- **Short frame:** 3 rows then `done_readout` → `short_err`=1, `m_valid` never asserts, state IDLE. A following good frame drains correctly; `clr_err` clears the flag.
- **Long frame:** 5 rows then `done_readout` → `long_err`=1; the first 4 rows drain; the fifth row is absent.
- **Overrun and simultaneity:** a `row_valid` during DRAIN sets `overrun_err` and the output words are unchanged. `row_valid` coincident with `done_readout` on the 4th row is accepted and the frame drains.
- **Reset mid-DRAIN:** assert `rst` after 2 handshakes → all outputs 0 immediately. A new 4-row frame then drains from index 0.

Source files
------------

// File: rtl/stabilizer_readout_collector.sv
// Stabilizer readout collector: captures one rotated-out stabilizer frame,
// checks its row count and replays it to the host over valid/ready.
module stabilizer_readout_collector #(
  parameter int NUM_QUBIT = 4,
  parameter int PHASE_W   = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               row_valid,
  input  logic [2*NUM_QUBIT-1:0]             row_literal,
  input  logic [PHASE_W-1:0]                 row_phase,
  input  logic                               done_readout,
  input  logic                               m_ready,
  input  logic                               clr_err,
  output logic                               m_valid,
  output logic [2*NUM_QUBIT+PHASE_W-1:0]     m_data,
  output logic                               m_last,
  output logic [$clog2(NUM_QUBIT)-1:0]       m_index,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               short_err,
  output logic                               long_err,
  output logic                               overrun_err
);

  localparam int DW = 2*NUM_QUBIT + PHASE_W;
  localparam int IW = $clog2(NUM_QUBIT);
  localparam int CW = $clog2(NUM_QUBIT + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_QUBIT);
  localparam logic [IW-1:0] LAST = IW'(NUM_QUBIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] wr_cnt, wr_cnt_n, cnt_upd;
  logic [IW-1:0] rd_ptr, rd_ptr_n;
  logic          we;
  logic [IW-1:0] wa;
  logic          short_set, long_set, ovr_set;
  logic          fd_n;
  logic [DW-1:0] mem [NUM_QUBIT];

  always_comb begin
    state_n   = state;
    wr_cnt_n  = wr_cnt;
    rd_ptr_n  = rd_ptr;
    cnt_upd   = wr_cnt;
    we        = 1'b0;
    wa        = wr_cnt[IW-1:0];
    short_set = 1'b0;
    long_set  = 1'b0;
    ovr_set   = 1'b0;
    fd_n      = 1'b0;
    unique case (state)
      IDLE: begin
        if (row_valid) begin
          we = 1'b1;
          wa = '0;
        end
        // a one-row frame ending at once is still short
        if (done_readout) begin
          short_set = 1'b1;
          wr_cnt_n  = '0;
        end else if (row_valid) begin
          wr_cnt_n = CW'(1);
          state_n  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (row_valid) begin
          if (wr_cnt != FULL) begin
            we      = 1'b1;
            cnt_upd = wr_cnt + CW'(1);
          end else begin
            long_set = 1'b1;
          end
        end
        wr_cnt_n = cnt_upd;
        if (done_readout) begin
          if (cnt_upd == FULL) begin
            state_n  = DRAIN;
            rd_ptr_n = '0;
          end else begin
            short_set = 1'b1;
            wr_cnt_n  = '0;
            state_n   = IDLE;
          end
        end
      end
      DRAIN: begin
        ovr_set = row_valid;
        if (m_ready) begin
          if (rd_ptr == LAST) begin
            fd_n     = 1'b1;
            state_n  = IDLE;
            wr_cnt_n = '0;
            rd_ptr_n = '0;
          end else begin
            rd_ptr_n = rd_ptr + IW'(1);
          end
        end
      end
      default: begin
        state_n  = IDLE;
        wr_cnt_n = '0;
        rd_ptr_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      rd_ptr      <= '0;
      frame_done  <= 1'b0;
      short_err   <= 1'b0;
      long_err    <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state       <= state_n;
      wr_cnt      <= wr_cnt_n;
      rd_ptr      <= rd_ptr_n;
      frame_done  <= fd_n;
      short_err   <= (short_err & ~clr_err) | short_set;
      long_err    <= (long_err & ~clr_err) | long_set;
      overrun_err <= (overrun_err & ~clr_err) | ovr_set;
    end
  end

  // row buffer needs no reset; outputs are masked outside DRAIN
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= {row_phase, row_literal};
  end

  assign m_valid = (state == DRAIN);
  assign busy    = (state != IDLE);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;
  assign m_index = m_valid ? rd_ptr : '0;
  assign m_last  = m_valid && (rd_ptr == LAST);

endmodule

// File: tb/tb_stabilizer_readout_collector.sv
// Directed bench for stabilizer_readout_collector: vector table for
// nominal/backpressure frames, hand sequences for error and reset cases.
module tb_stabilizer_readout_collector;

  localparam int N  = 4;
  localparam int PW = 2;

  logic        clk = 0;
  logic        rst = 1;
  logic        row_valid = 0;
  logic [7:0]  row_literal = 0;
  logic [1:0]  row_phase = 0;
  logic        done_readout = 0;
  logic        m_ready = 0;
  logic        clr_err = 0;
  logic        m_valid;
  logic [9:0]  m_data;
  logic        m_last;
  logic [1:0]  m_index;
  logic        busy;
  logic        frame_done;
  logic        short_err;
  logic        long_err;
  logic        overrun_err;
  logic [18:0] obs;

  int n_chk = 0;
  int n_fail = 0;

  stabilizer_readout_collector #(.NUM_QUBIT(N), .PHASE_W(PW)) dut (
    .clk(clk), .rst(rst),
    .row_valid(row_valid), .row_literal(row_literal),
    .row_phase(row_phase), .done_readout(done_readout),
    .m_ready(m_ready), .clr_err(clr_err),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_index(m_index), .busy(busy), .frame_done(frame_done),
    .short_err(short_err), .long_err(long_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  assign obs = {m_valid, m_data, m_last, m_index, busy,
                frame_done, short_err, long_err, overrun_err};

  typedef struct {
    logic        rv;
    logic [9:0]  d;
    logic        dn;
    logic        rdy;
    logic        clr;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [18:0] ex(logic v, logic [9:0] d,
      logic l, logic [1:0] i, logic b, logic fd, logic [2:0] e);
    return {v, d, l, i, b, fd, e};
  endfunction

  function automatic vec_t mk(logic rv, logic [9:0] d, logic dn,
      logic rdy, logic [18:0] e);
    vec_t t;
    t.rv = rv; t.d = d; t.dn = dn; t.rdy = rdy; t.clr = 1'b0;
    t.exp = e;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic rv, input logic [9:0] d,
      input logic dn, input logic rdy, input logic clr);
    @(negedge clk);
    row_valid = rv;
    row_phase = d[9:8];
    row_literal = d[7:0];
    done_readout = dn;
    m_ready = rdy;
    clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [39:0] rows);
    for (int i = 0; i < N; i++) tick(1, rows[i*10 +: 10], 0, 0, 0);
    tick(0, 10'h0, 1, 0, 0);
  endtask

  task automatic drain(input logic [39:0] rows, input string tag);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_valid"}, 32'(m_valid), 32'd1);
      chk({tag, "_data"}, 32'(m_data), 32'(rows[i*10 +: 10]));
      chk({tag, "_index"}, 32'(m_index), 32'(i));
      chk({tag, "_last"}, 32'(m_last), 32'(i == N - 1));
      tick(0, 10'h0, 0, 1, 0);
    end
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  localparam logic [39:0] FA = {10'h0D4, 10'h0C3, 10'h0B2, 10'h0A1};
  localparam logic [39:0] FB = {10'h204, 10'h203, 10'h202, 10'h201};
  localparam logic [39:0] FC = {10'h304, 10'h303, 10'h302, 10'h301};
  localparam logic [39:0] FD = {10'h1E4, 10'h1E3, 10'h1E2, 10'h1E1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // nominal frame, drained with m_ready high
    tbl.push_back(mk(1, 10'h0A1, 0, 0, ex(0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 10'h0B2, 0, 0, ex(0, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(mk(1, 10'h0C3, 0, 0, ex(0, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(mk(1, 10'h0D4, 0, 0, ex(0, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 1, 0, ex(0, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 0, 1, ex(1, 10'h0A1, 0, 0, 1, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 0, 1, ex(1, 10'h0B2, 0, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 0, 1, ex(1, 10'h0C3, 0, 2, 1, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 0, 1, ex(1, 10'h0D4, 1, 3, 1, 0, 0)));
    // next frame starts in the frame_done cycle; host stalls 1,0,0,...
    tbl.push_back(mk(1, 10'h0A1, 0, 0, ex(0, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(mk(1, 10'h0B2, 0, 0, ex(0, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(mk(1, 10'h0C3, 0, 0, ex(0, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(mk(1, 10'h0D4, 0, 0, ex(0, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 1, 0, ex(0, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 0, 1, ex(1, 10'h0A1, 0, 0, 1, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 0, 0, ex(1, 10'h0B2, 0, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 0, 0, ex(1, 10'h0B2, 0, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 0, 1, ex(1, 10'h0B2, 0, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 0, 0, ex(1, 10'h0C3, 0, 2, 1, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 0, 0, ex(1, 10'h0C3, 0, 2, 1, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 0, 1, ex(1, 10'h0C3, 0, 2, 1, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 0, 0, ex(1, 10'h0D4, 1, 3, 1, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 0, 0, ex(1, 10'h0D4, 1, 3, 1, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 0, 1, ex(1, 10'h0D4, 1, 3, 1, 0, 0)));
    tbl.push_back(mk(0, 10'h000, 0, 0, ex(0, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(mk(0, 10'h000, 0, 0, ex(0, 0, 0, 0, 0, 0, 0)));

    @(posedge clk);
    #1;
    chk("reset_outputs", 32'(obs), 32'd0);
    @(negedge clk);
    rst = 0;

    foreach (tbl[i]) begin
      @(negedge clk);
      row_valid = tbl[i].rv;
      row_phase = tbl[i].d[9:8];
      row_literal = tbl[i].d[7:0];
      done_readout = tbl[i].dn;
      m_ready = tbl[i].rdy;
      clr_err = tbl[i].clr;
      #1;
      chk($sformatf("vec%0d", i), 32'(obs), 32'(tbl[i].exp));
    end

    // short frame, then a good frame, then clear
    tick(1, 10'h111, 0, 0, 0);
    tick(1, 10'h122, 0, 0, 0);
    tick(1, 10'h133, 0, 0, 0);
    tick(0, 10'h000, 1, 0, 0);
    chk("short_err_set", 32'(short_err), 32'd1);
    chk("short_busy", 32'(busy), 32'd0);
    tick(0, 10'h000, 0, 1, 0);
    chk("short_no_valid", 32'(m_valid), 32'd0);
    load(FB);
    drain(FB, "after_short");
    chk("short_sticky", 32'(short_err), 32'd1);
    tick(0, 10'h000, 0, 0, 1);
    chk("short_cleared", 32'(short_err), 32'd0);

    // clr_err with a coincident error event: the set wins
    tick(0, 10'h000, 1, 0, 1);
    chk("clr_vs_set", 32'(short_err), 32'd1);
    tick(0, 10'h000, 0, 0, 1);
    chk("clr_again", 32'(short_err), 32'd0);

    // long frame: fifth row dropped
    for (int i = 0; i < N; i++) tick(1, FC[i*10 +: 10], 0, 0, 0);
    chk("long_not_yet", 32'(long_err), 32'd0);
    tick(1, 10'h3FF, 0, 0, 0);
    chk("long_err_set", 32'(long_err), 32'd1);
    tick(0, 10'h000, 1, 0, 0);
    drain(FC, "long");
    tick(0, 10'h000, 0, 1, 0);
    chk("long_no_fifth", 32'(m_valid), 32'd0);
    tick(0, 10'h000, 0, 0, 1);
    chk("long_cleared", 32'(long_err), 32'd0);

    // 4th row with done_readout, then overrun during DRAIN
    for (int i = 0; i < N - 1; i++) tick(1, FD[i*10 +: 10], 0, 0, 0);
    tick(1, FD[30 +: 10], 1, 0, 0);
    chk("simul_valid", 32'(m_valid), 32'd1);
    tick(1, 10'h3FF, 0, 0, 0);
    chk("overrun_set", 32'(overrun_err), 32'd1);
    chk("overrun_data", 32'(m_data), 32'(FD[9:0]));
    chk("overrun_index", 32'(m_index), 32'd0);
    drain(FD, "simul");
    chk("overrun_sticky", 32'(overrun_err), 32'd1);

    // reset mid-DRAIN after two handshakes
    load(FA);
    tick(0, 10'h000, 0, 1, 0);
    tick(0, 10'h000, 0, 1, 0);
    chk("pre_reset_index", 32'(m_index), 32'd2);
    @(negedge clk);
    rst = 1;
    m_ready = 0;
    #1;
    chk("mid_drain_reset", 32'(obs), 32'd0);
    @(posedge clk);
    #1;
    chk("reset_no_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst = 0;
    load(FB);
    drain(FB, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
